// File: rtl/gpio_cfg_serializer_if.sv
// gpio_cfg_serializer_if: register port, transfer handshake and serial chain of the pad config serializer
interface gpio_cfg_serializer_if #(
  parameter int NPADS    = 38,
  parameter int CFG_BITS = 13
);
  localparam int AW = NPADS > 1 ? $clog2(NPADS) : 1;
  logic                cfg_we;
  logic [AW-1:0]       cfg_addr;
  logic [CFG_BITS-1:0] cfg_wdata;
  logic [CFG_BITS-1:0] cfg_rdata;
  logic                cfg_err;
  logic                xfer_start;
  logic                busy;
  logic                done;
  logic                serial_data;
  logic                serial_clock;
  logic                serial_load;
  logic [NPADS-1:0]    in_not_out_o;
  modport master (
    output cfg_we, cfg_addr, cfg_wdata, xfer_start,
    input  cfg_rdata, cfg_err, busy, done, serial_data, serial_clock, serial_load, in_not_out_o
  );
  modport slave (
    input  cfg_we, cfg_addr, cfg_wdata, xfer_start,
    output cfg_rdata, cfg_err, busy, done, serial_data, serial_clock, serial_load, in_not_out_o
  );
endinterface

// File: rtl/gpio_cfg_serializer.sv
// gpio_cfg_serializer: shadows per-pad config words, shifts them out serially and applies OEB bits after load.
// Define GPIO_CFG_AUTO_LOAD_EN to start one transfer automatically on the first edge after reset release.
module gpio_cfg_serializer #(
  parameter int                  NPADS       = 38,
  parameter int                  CFG_BITS    = 13,
  parameter int                  OEB_BIT     = 1,
  parameter logic [CFG_BITS-1:0] DEFAULT_CFG = 13'h0403,
  parameter int                  CLK_DIV     = 2
) (
  input logic                  clk,
  input logic                  rst,
  gpio_cfg_serializer_if.slave bus
);
  localparam int AW = NPADS > 1 ? $clog2(NPADS) : 1;
  localparam int BW = CFG_BITS > 1 ? $clog2(CFG_BITS) : 1;
  localparam int DW = CLK_DIV > 1 ? $clog2(CLK_DIV) : 1;
  localparam logic [AW:0]   NP       = (AW+1)'(NPADS);
  localparam logic [AW-1:0] PAD_LAST = AW'(NPADS - 1);
  localparam logic [BW-1:0] BIT_LAST = BW'(CFG_BITS - 1);
  localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);

  typedef enum logic [2:0] {IDLE, SHIFT_LO, SHIFT_HI, LOAD, DONE} state_t;

  state_t              state_q, state_d;
  logic [AW-1:0]       pad_q, pad_d;
  logic [BW-1:0]       bit_q, bit_d;
  logic [DW-1:0]       div_q, div_d;
  logic [CFG_BITS-1:0] shadow_q [NPADS];
  logic [CFG_BITS-1:0] shadow_d [NPADS];
  logic [NPADS-1:0]    oeb_q, oeb_d;
  logic sdata_q, sdata_d, sclk_q, sclk_d, sload_q, sload_d;
  logic busy_q, busy_d, done_q, done_d, err_q, err_d;
  logic start, addr_ok, wr_ok, phase_end;

`ifdef GPIO_CFG_AUTO_LOAD_EN
  logic auto_q;
  always_ff @(posedge clk or posedge rst)
    if (rst) auto_q <= 1'b1;
    else     auto_q <= 1'b0;
  assign start = bus.xfer_start | auto_q;
`else
  assign start = bus.xfer_start;
`endif

  assign addr_ok   = {1'b0, bus.cfg_addr} < NP;
  assign wr_ok     = bus.cfg_we && addr_ok && state_q == IDLE;
  assign phase_end = div_q == DIV_LAST;

  always_comb begin
    state_d  = state_q;
    pad_d    = pad_q;
    bit_d    = bit_q;
    div_d    = '0;
    shadow_d = shadow_q;
    oeb_d    = oeb_q;
    if (wr_ok) shadow_d[bus.cfg_addr] = bus.cfg_wdata;
    case (state_q)
      IDLE: if (start) begin
        state_d = SHIFT_LO;
        pad_d   = PAD_LAST;
        bit_d   = BIT_LAST;
      end
      SHIFT_LO: begin
        div_d = phase_end ? '0 : div_q + 1'b1;
        if (phase_end) state_d = SHIFT_HI;
      end
      SHIFT_HI: begin
        div_d = phase_end ? '0 : div_q + 1'b1;
        if (phase_end) begin
          state_d = (pad_q == '0 && bit_q == '0) ? LOAD : SHIFT_LO;
          bit_d   = bit_q == '0 ? BIT_LAST : bit_q - 1'b1;
          pad_d   = bit_q == '0 ? pad_q - 1'b1 : pad_q;
        end
      end
      LOAD: begin
        div_d = phase_end ? '0 : div_q + 1'b1;
        if (phase_end) begin
          state_d = DONE;
          for (int i = 0; i < NPADS; i++) oeb_d[i] = shadow_q[i][OEB_BIT];
        end
      end
      default: state_d = IDLE;
    endcase
    // outputs are decoded from the next state so they register in step with state_q
    busy_d  = state_d inside {SHIFT_LO, SHIFT_HI, LOAD};
    done_d  = state_d == DONE;
    sclk_d  = state_d == SHIFT_HI;
    sload_d = state_d == LOAD;
    sdata_d = state_d == SHIFT_LO ? shadow_q[pad_d][bit_d] : state_d == SHIFT_HI ? sdata_q : 1'b0;
    err_d   = bus.cfg_we && !wr_ok;
  end

  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state_q  <= IDLE;
      pad_q    <= '0;
      bit_q    <= '0;
      div_q    <= '0;
      shadow_q <= '{default: DEFAULT_CFG};
      oeb_q    <= {NPADS{DEFAULT_CFG[OEB_BIT]}};
      sdata_q  <= 1'b0;
      sclk_q   <= 1'b0;
      sload_q  <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      pad_q    <= pad_d;
      bit_q    <= bit_d;
      div_q    <= div_d;
      shadow_q <= shadow_d;
      oeb_q    <= oeb_d;
      sdata_q  <= sdata_d;
      sclk_q   <= sclk_d;
      sload_q  <= sload_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      err_q    <= err_d;
    end

  assign bus.cfg_rdata    = addr_ok ? shadow_q[bus.cfg_addr] : '0;
  assign bus.cfg_err      = err_q;
  assign bus.busy         = busy_q;
  assign bus.done         = done_q;
  assign bus.serial_data  = sdata_q;
  assign bus.serial_clock = sclk_q;
  assign bus.serial_load  = sload_q;
  assign bus.in_not_out_o = oeb_q;
endmodule
